// File: rtl/nyakuo_pkg.sv
// Shared types and encodings for the nyakuo core's memory path.
// Load/store op codes are {store, funct3}.
package nyakuo_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        OP_LB  = {1'b0, F3_B},
        OP_LH  = {1'b0, F3_H},
        OP_LW  = {1'b0, F3_W},
        OP_LBU = {1'b0, F3_BU},
        OP_LHU = {1'b0, F3_HU},
        OP_SB  = {1'b1, F3_B},
        OP_SH  = {1'b1, F3_H},
        OP_SW  = {1'b1, F3_W}
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } lsu_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/nyakuo_lsu_align.sv
// Byte-lane steering for loads and stores: strobes, replicated store data,
// extended load data and the size-vs-address misalignment flag.
module nyakuo_lsu_align
    import nyakuo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata_lanes,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        rbyte       = 8'h00;
        rhalf       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wstrb       = 4'b0000;
        wdata_lanes = '0;
        rdata_ext   = '0;
        misaligned  = 1'b0;

        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase

        case (op)
            OP_LB:  rdata_ext = {{(XLEN-8){rbyte[7]}}, rbyte};
            OP_LBU: rdata_ext = {{(XLEN-8){1'b0}}, rbyte};
            OP_LH: begin
                misaligned = addr_lo[0];
                rdata_ext  = {{(XLEN-16){rhalf[15]}}, rhalf};
            end
            OP_LHU: begin
                misaligned = addr_lo[0];
                rdata_ext  = {{(XLEN-16){1'b0}}, rhalf};
            end
            OP_LW: begin
                misaligned = |addr_lo;
                rdata_ext  = rdata;
            end
            OP_SB: begin
                wstrb       = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            OP_SH: begin
                misaligned  = addr_lo[0];
                wstrb       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
            end
            OP_SW: begin
                misaligned  = |addr_lo;
                wstrb       = 4'b1111;
                wdata_lanes = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nyakuo_lsu.sv
// Load/store unit: accepts one decoded memory op at a time, runs a single
// data-bus transaction (or faults early) and returns a one-cycle response.
module nyakuo_lsu
    import nyakuo_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_misaligned,
    output logic              resp_illegal,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    lsu_state_t        state, state_next;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [4:0]        rd_q;

    logic [XLEN-1:0]   resp_rdata_q;
    logic [4:0]        resp_rd_q;
    logic              resp_mis_q;
    logic              resp_ill_q;

    logic [3:0]        al_op;
    logic [1:0]        al_addr;
    logic [XLEN-1:0]   al_wdata_in;
    logic [3:0]        al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              al_mis;

    logic              accept;
    logic              req_legal;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched op.
    assign al_op       = (state == IDLE) ? req_op         : op_q;
    assign al_addr     = (state == IDLE) ? req_addr[1:0]  : addr_q[1:0];
    assign al_wdata_in = (state == IDLE) ? req_wdata      : wdata_q;

    assign accept    = (state == IDLE) && req_valid;
    assign req_legal = op_is_legal(req_op);

    nyakuo_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .op          (al_op),
        .addr_lo     (al_addr),
        .wdata       (al_wdata_in),
        .rdata       (dmem_rdata),
        .wstrb       (al_wstrb),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_mis)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        dmem_addr       = '0;
        dmem_wstrb      = 4'b0000;
        dmem_wdata      = '0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_rd         = '0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_legal || al_mis) state_next = RESP;
                    else                      state_next = REQ;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = op_is_store(op_q);
                dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                dmem_wstrb = al_wstrb;
                dmem_wdata = op_is_store(op_q) ? al_wdata : '0;
                if (dmem_gnt) state_next = op_is_store(op_q) ? RESP : WAIT_R;
            end
            WAIT_R: begin
                if (dmem_rvalid) state_next = RESP;
            end
            RESP: begin
                resp_valid      = 1'b1;
                resp_rdata      = resp_rdata_q;
                resp_rd         = resp_rd_q;
                resp_misaligned = resp_mis_q;
                resp_illegal    = resp_ill_q;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response fields are cleared at accept so stores and faults report rdata/rd of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q         <= req_op;
                addr_q       <= req_addr;
                wdata_q      <= req_wdata;
                rd_q         <= req_rd;
                resp_rdata_q <= '0;
                resp_rd_q    <= '0;
                resp_mis_q   <= req_legal && al_mis;
                resp_ill_q   <= !req_legal;
            end
            if (state == WAIT_R && dmem_rvalid) begin
                resp_rdata_q <= al_rdata;
                resp_rd_q    <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_nyakuo_lsu.sv
// Self-checking bench for nyakuo_lsu: directed vector table, random ops
// against a byte-level reference model, and reset-abort sequences.
module tb_nyakuo_lsu;

    localparam logic [3:0] C_LB  = 4'h0;
    localparam logic [3:0] C_LH  = 4'h1;
    localparam logic [3:0] C_LW  = 4'h2;
    localparam logic [3:0] C_LBU = 4'h4;
    localparam logic [3:0] C_LHU = 4'h5;
    localparam logic [3:0] C_SB  = 4'h8;
    localparam logic [3:0] C_SH  = 4'h9;
    localparam logic [3:0] C_SW  = 4'hA;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nyakuo_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_rd         (resp_rd),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata)
    );

    typedef struct {
        bit          has_req;
        bit          we;
        logic [31:0] daddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        bit          mis;
        bit          ill;
        int          lat;
    } exp_t;

    typedef struct {
        bit          saw_req;
        bit          we;
        logic [31:0] daddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          stable;
        bit          ready_low;
        bit          extra_req;
        bit          one_shot;
        int          lat;
        logic [31:0] rdata;
        logic [4:0]  rd;
        bit          mis;
        bit          ill;
    } obs_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] mem;
        int          gnt;
        int          rv;
        bit          has_req;
        bit          we;
        logic [31:0] daddr;
        logic [3:0]  strb;
        logic [31:0] ewdata;
        logic [31:0] rdata;
        logic [4:0]  erd;
        bit          mis;
        bit          ill;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: op size in bytes, byte-lane arithmetic, cycle latency.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd,
                                   input logic [31:0] mem, input int gnt_dly, input int rv_dly);
        exp_t            e;
        int              size;
        int              off;
        bit              sgn;
        bit              legal;
        longint unsigned mask;
        longint unsigned val;
        e     = '{default: 0};
        size  = 1;
        sgn   = 1'b0;
        legal = 1'b1;
        case (op)
            C_LB:  begin size = 1; sgn = 1'b1; end
            C_LH:  begin size = 2; sgn = 1'b1; end
            C_LW:  size = 4;
            C_LBU: size = 1;
            C_LHU: size = 2;
            C_SB:  size = 1;
            C_SH:  size = 2;
            C_SW:  size = 4;
            default: legal = 1'b0;
        endcase
        off = int'(addr % 32'd4);
        if (!legal) begin
            e.ill = 1'b1;
            e.lat = 1;
            return e;
        end
        if ((addr % 32'(size)) != 0) begin
            e.mis = 1'b1;
            e.lat = 1;
            return e;
        end
        e.has_req = 1'b1;
        e.we      = op[3];
        e.daddr   = addr - 32'(off);
        mask      = (64'd1 << (8 * size)) - 64'd1;
        if (op[3]) begin
            e.strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            e.lat = 2 + gnt_dly;
        end else begin
            val = (64'(mem) >> (8 * off)) & mask;
            if (sgn && val[8*size-1]) val = val | ~mask;
            e.rdata = val[31:0];
            e.rd    = rd;
            e.lat   = 3 + gnt_dly + rv_dly;
        end
        return e;
    endfunction

    // Issues one op and plays the memory side; keeps junk on req_* while busy.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] mem,
                         input int gnt_dly, input int rv_dly, output obs_t o);
        int reqn;
        int rv_due;
        bit granted;
        o           = '{default: 0};
        o.lat       = -1;
        o.stable    = 1'b1;
        o.ready_low = 1'b1;
        reqn        = 0;
        rv_due      = -1;
        granted     = 1'b0;
        @(negedge clk);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rd      = rd;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_op      = 4'($urandom);
            req_addr    = $urandom;
            req_wdata   = $urandom;
            req_rd      = 5'($urandom);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (req_ready) o.ready_low = 1'b0;
            if (resp_valid) begin
                o.lat   = k;
                o.rdata = resp_rdata;
                o.rd    = resp_rd;
                o.mis   = resp_misaligned;
                o.ill   = resp_illegal;
                break;
            end
            if (dmem_req) begin
                if (granted) begin
                    o.extra_req = 1'b1;
                end else begin
                    if (!o.saw_req) begin
                        o.saw_req = 1'b1;
                        o.we      = dmem_we;
                        o.daddr   = dmem_addr;
                        o.strb    = dmem_wstrb;
                        o.wdata   = dmem_wdata;
                    end else if (dmem_we !== o.we || dmem_addr !== o.daddr ||
                                 dmem_wstrb !== o.strb || dmem_wdata !== o.wdata) begin
                        o.stable = 1'b0;
                    end
                    if (reqn == gnt_dly) begin
                        dmem_gnt = 1'b1;
                        granted  = 1'b1;
                        rv_due   = k + 1 + rv_dly;
                    end else begin
                        reqn++;
                        dmem_rvalid = 1'b1;
                    end
                end
            end
            if (granted && k == rv_due) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem;
            end
        end
        req_valid   = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        o.one_shot = !resp_valid && req_ready;
        if (o.lat < 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic compare(input string n, input obs_t o, input exp_t e);
        check({n, ".latency"},   32'(o.lat),  32'(e.lat));
        check({n, ".rdata"},     o.rdata,     e.rdata);
        check({n, ".rd"},        32'(o.rd),   32'(e.rd));
        check({n, ".misalign"},  32'(o.mis),  32'(e.mis));
        check({n, ".illegal"},   32'(o.ill),  32'(e.ill));
        check({n, ".dmem_req"},  32'(o.saw_req), 32'(e.has_req));
        check({n, ".ready_low"}, 32'(o.ready_low), 32'd1);
        check({n, ".one_shot"},  32'(o.one_shot),  32'd1);
        check({n, ".req_after_gnt"}, 32'(o.extra_req), 32'd0);
        if (e.has_req && o.saw_req) begin
            check({n, ".stable"}, 32'(o.stable), 32'd1);
            check({n, ".addr"},   o.daddr,       e.daddr);
            check({n, ".we"},     32'(o.we),     32'(e.we));
            check({n, ".wstrb"},  32'(o.strb),   32'(e.strb));
            if (e.we) check({n, ".wdata"}, o.wdata, e.wdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[18];
        obs_t        o;
        exp_t        e;
        logic [3:0]  legal_ops[8];
        logic [3:0]  op;
        logic [31:0] addr;

        legal_ops = '{C_LB, C_LH, C_LW, C_LBU, C_LHU, C_SB, C_SH, C_SW};

        //         name              op     addr          wdata         rd  mem           g  r  req we daddr         strb   ewdata        rdata         erd mis ill lat
        vecs[0]  = '{"sw_0x100",       C_SW,  32'h100, 32'hDEADBEEF, 5'd7,  32'h0,        0, 0, 1, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        5'd0,  0, 0, 2};
        vecs[1]  = '{"sb_0x103",       C_SB,  32'h103, 32'h000000A5, 5'd3,  32'h0,        0, 0, 1, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        5'd0,  0, 0, 2};
        vecs[2]  = '{"lb_0x202",       C_LB,  32'h202, 32'h0,        5'd5,  32'h12F45678, 0, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFFF4, 5'd5,  0, 0, 3};
        vecs[3]  = '{"lbu_0x202",      C_LBU, 32'h202, 32'h0,        5'd5,  32'h12F45678, 0, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'h000000F4, 5'd5,  0, 0, 3};
        vecs[4]  = '{"lhu_0x202",      C_LHU, 32'h202, 32'h0,        5'd5,  32'h12F45678, 0, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'h000012F4, 5'd5,  0, 0, 3};
        vecs[5]  = '{"lh_0x200",       C_LH,  32'h200, 32'h0,        5'd9,  32'h12348765, 0, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFF8765, 5'd9,  0, 0, 3};
        vecs[6]  = '{"lw_0x204",       C_LW,  32'h204, 32'h0,        5'd31, 32'hCAFEF00D, 0, 1, 1, 0, 32'h204, 4'b0000, 32'h0,        32'hCAFEF00D, 5'd31, 0, 0, 4};
        vecs[7]  = '{"lb_0x203",       C_LB,  32'h203, 32'h0,        5'd1,  32'h7F000000, 0, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'h0000007F, 5'd1,  0, 0, 3};
        vecs[8]  = '{"lh_0x201_mis",   C_LH,  32'h201, 32'h0,        5'd4,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  1, 0, 1};
        vecs[9]  = '{"lw_0x202_mis",   C_LW,  32'h202, 32'h0,        5'd4,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  1, 0, 1};
        vecs[10] = '{"sh_0x103_mis",   C_SH,  32'h103, 32'h1111,     5'd0,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  1, 0, 1};
        vecs[11] = '{"sw_0x101_mis",   C_SW,  32'h101, 32'h2222,     5'd0,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  1, 0, 1};
        vecs[12] = '{"op3_illegal",    4'h3,  32'h201, 32'h0,        5'd6,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  0, 1, 1};
        vecs[13] = '{"opB_illegal",    4'hB,  32'h101, 32'h0,        5'd6,  32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        5'd0,  0, 1, 1};
        vecs[14] = '{"sh_0x102_stall", C_SH,  32'h102, 32'h1234ABCD, 5'd2,  32'h0,        3, 0, 1, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0,        5'd0,  0, 0, 5};
        vecs[15] = '{"sh_0x100",       C_SH,  32'h100, 32'h1234ABCD, 5'd2,  32'h0,        0, 0, 1, 1, 32'h100, 4'b0011, 32'hABCDABCD, 32'h0,        5'd0,  0, 0, 2};
        vecs[16] = '{"sb_0x101_stall", C_SB,  32'h101, 32'hFFFFFF3C, 5'd2,  32'h0,        1, 0, 1, 1, 32'h100, 4'b0010, 32'h3C3C3C3C, 32'h0,        5'd0,  0, 0, 3};
        vecs[17] = '{"lhu_0x200_slow", C_LHU, 32'h200, 32'h0,        5'd12, 32'h00008001, 2, 2, 1, 0, 32'h200, 4'b0000, 32'h0,        32'h00008001, 5'd12, 0, 0, 7};

        // Reset state, with a request held high to show reset dominates.
        rst         = 1'b1;
        req_valid   = 1'b1;
        req_op      = C_SW;
        req_addr    = 32'h100;
        req_wdata   = 32'hFFFFFFFF;
        req_rd      = 5'd1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset.req_ready",  32'(req_ready),  32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.dmem_req",   32'(dmem_req),   32'd0);
        check("reset.dmem_we",    32'(dmem_we),    32'd0);
        check("reset.dmem_addr",  dmem_addr,       32'd0);
        check("reset.dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        check("reset.dmem_wdata", dmem_wdata,      32'd0);
        check("reset.resp_rdata", resp_rdata,      32'd0);
        check("reset.resp_rd",    32'(resp_rd),    32'd0);
        check("reset.resp_flags", 32'({resp_misaligned, resp_illegal}), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("post_reset.idle", 32'({req_ready, dmem_req, resp_valid}), 32'b100);

        for (int i = 0; i < 18; i++) begin
            e         = '{default: 0};
            e.has_req = vecs[i].has_req;
            e.we      = vecs[i].we;
            e.daddr   = vecs[i].daddr;
            e.strb    = vecs[i].strb;
            e.wdata   = vecs[i].ewdata;
            e.rdata   = vecs[i].rdata;
            e.rd      = vecs[i].erd;
            e.mis     = vecs[i].mis;
            e.ill     = vecs[i].ill;
            e.lat     = vecs[i].lat;
            do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].mem,
                  vecs[i].gnt, vecs[i].rv, o);
            compare(vecs[i].name, o, e);
        end

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = C_LW;
        req_addr  = 32'h300;
        req_rd    = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_wait.dmem_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rst_wait.in_wait", 32'({dmem_req, req_ready, resp_valid}), 32'b000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait.idle", 32'({req_ready, dmem_req, resp_valid}), 32'b100);
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rst_wait.late_rvalid", 32'({req_ready, resp_valid}), 32'b10);
        @(negedge clk);
        check("rst_wait.no_resp", 32'(resp_valid), 32'd0);
        do_op(C_LW, 32'h304, 32'h0, 5'd8, 32'h89ABCDEF, 0, 0, o);
        compare("rst_wait.next_lw", o, model(C_LW, 32'h304, 32'h0, 5'd8, 32'h89ABCDEF, 0, 0));

        // Reset while the bus request is outstanding: dmem_req drops at that edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = C_SW;
        req_addr  = 32'h40;
        req_wdata = 32'h01020304;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_req.dmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req.dropped", 32'({dmem_req, dmem_we, dmem_wstrb, req_ready}), 32'b0000001);
        @(negedge clk);
        check("rst_req.no_resp", 32'({resp_valid, dmem_req}), 32'b00);

        // Random ops against the reference model.
        for (int n = 0; n < 300; n++) begin
            int          g;
            int          r;
            logic [31:0] wd;
            logic [31:0] mw;
            logic [4:0]  rd;
            if ($urandom_range(0, 9) == 0) op = 4'($urandom);
            else                           op = legal_ops[$urandom_range(0, 7)];
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            wd = $urandom;
            mw = $urandom;
            rd = 5'($urandom);
            g  = $urandom_range(0, 3);
            r  = $urandom_range(0, 3);
            do_op(op, addr, wd, rd, mw, g, r, o);
            compare($sformatf("rand%0d_op%h_a%h", n, op, addr), o, model(op, addr, wd, rd, mw, g, r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
